// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and the keyboard receiver.
//   ps2_state_t : transmitter sequencing states
//   FRAME_BITS  : host-driven bits after the start bit (d0..d7, parity, stop)
//   odd_parity  : parity bit that makes the nine data+parity bits odd
// -----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      RTS       = 3'd2,
      SHIFT     = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } ps2_state_t;

   localparam int FRAME_BITS = 10;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
// Brings one raw PS/2 pin into the system clock domain and debounces it.
// A new level is accepted only after FILTER_LEN consecutive samples that all
// differ from the current accepted level.
//
// Ports:
//   clk   in  : system clock
//   rst_n in  : asynchronous active-low reset
//   pin   in  : raw asynchronous line (idle high)
//   level out : filtered line level
//   fall  out : one-cycle pulse when level goes 1 -> 0 (same cycle level drops)
// -----------------------------------------------------------------------------
module ps2_line_sync #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic fall
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic             meta;
   logic             sync;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer; resets to the released (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         sync <= 1'b1;
      end else begin
         meta <= pin;
         sync <= meta;
      end
   end

   // Stability filter: any sample that agrees with the accepted level restarts
   // the run, so the counter never wraps past FILTER_LEN-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b1;
         fall  <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (sync == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
            level <= sync;
            cnt   <= '0;
            fall  <= level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift d0..d7,
// odd parity and stop on device clock falls, then sample the device ack.
// Lines are driven open-drain: an oe of 1 pulls the line low, 0 releases it.
//
// Optional build macro: PS2_TX_TIMEOUT_EN
//   defined   : start (clock release -> first fall) and packet (first fall ->
//               ack) watchdogs release the lines and end with tx_err.
//   undefined : no watchdogs; a silent device parks the block in SHIFT/ACK.
//
// Ports:
//   sys_clk     in  : system clock
//   sys_rst_n   in  : asynchronous active-low reset
//   tx_data     in  : command byte
//   tx_valid    in  : send request, taken when tx_ready is high
//   tx_ready    out : able to accept a byte
//   tx_done     out : one-cycle pulse, byte acknowledged
//   tx_err      out : one-cycle pulse, NACK or watchdog expiry
//   ps2_clk_in  in  : raw PS/2 clock pin
//   ps2_dat_in  in  : raw PS/2 data pin
//   ps2_clk_oe  out : pull PS/2 clock low
//   ps2_dat_oe  out : pull PS/2 data low
// -----------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int INHIBIT_CYCLES  = CLK_HZ / 10_000,
   parameter int START_TO_CYCLES = CLK_HZ / 1000 * 15,
   parameter int PKT_TO_CYCLES   = CLK_HZ / 500,
   parameter int FILTER_LEN      = 8
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int IDX_W = $clog2(FRAME_BITS);

   ps2_state_t             state;
   ps2_state_t             state_nx;

   logic                   clk_lvl;
   logic                   clk_fall;
   logic                   dat_lvl;
   logic                   dat_fall_unused;

   logic [FRAME_BITS-1:0]  frame_q;
   logic [IDX_W-1:0]       idx_q;
   logic [INH_W-1:0]       inh_cnt;
   logic                   dat_q;
   logic                   err_q;

   logic                   accept;
   logic                   inh_done;
   logic                   lines_idle;
   logic                   timeout;

   // Parameters only consumed when the watchdogs are built.
   wire cfg_unused = (CLK_HZ > 0) && (START_TO_CYCLES > 0) && (PKT_TO_CYCLES > 0);

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .pin   (ps2_clk_in),
      .level (clk_lvl),
      .fall  (clk_fall)
   );

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_dat_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .pin   (ps2_dat_in),
      .level (dat_lvl),
      .fall  (dat_fall_unused)
   );

   assign accept     = tx_valid && tx_ready;
   assign inh_done   = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
   assign lines_idle = clk_lvl && dat_lvl;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_MAX = (START_TO_CYCLES > PKT_TO_CYCLES) ? START_TO_CYCLES : PKT_TO_CYCLES;
   localparam int WD_W   = (WD_MAX > 1) ? $clog2(WD_MAX) : 1;

   logic [WD_W-1:0] wd_cnt;
   logic            armed;   // first device fall seen: packet limit applies

   // One counter serves both limits; it restarts on the first device fall.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wd_cnt <= '0;
         armed  <= 1'b0;
      end else if (state == RTS) begin
         wd_cnt <= '0;
         armed  <= 1'b0;
      end else if (state == SHIFT || state == ACK) begin
         if (clk_fall && !armed) begin
            wd_cnt <= '0;
            armed  <= 1'b1;
         end else if (wd_cnt != WD_W'(WD_MAX - 1)) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end

   assign timeout = (state == SHIFT || state == ACK) &&
                    (armed ? (wd_cnt >= WD_W'(PKT_TO_CYCLES - 1))
                           : (wd_cnt >= WD_W'(START_TO_CYCLES - 1)));
`else
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:      if (accept) state_nx = INHIBIT;
         INHIBIT:   if (inh_done) state_nx = RTS;
         RTS:       state_nx = SHIFT;
         SHIFT: begin
            if (timeout)
               state_nx = WAIT_IDLE;
            else if (clk_fall && idx_q == IDX_W'(FRAME_BITS - 1))
               state_nx = ACK;
         end
         ACK:       if (timeout || clk_fall) state_nx = WAIT_IDLE;
         // Ready rises with the completion pulse, so a new byte may be taken here.
         WAIT_IDLE: if (lines_idle) state_nx = accept ? INHIBIT : IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Frame, bit index, inhibit timer, data drive and result flag
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         frame_q <= '0;
         idx_q   <= '0;
         inh_cnt <= '0;
         dat_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE, WAIT_IDLE: begin
               if (accept) begin
                  frame_q <= {1'b1, odd_parity(tx_data), tx_data};
                  inh_cnt <= '0;
                  err_q   <= 1'b0;
               end
            end
            INHIBIT: begin
               if (inh_done) begin
                  dat_q <= 1'b1;          // start bit while the clock is still held
                  idx_q <= '0;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (timeout) begin
                  dat_q <= 1'b0;
                  err_q <= 1'b1;
               end else if (clk_fall) begin
                  dat_q <= ~frame_q[idx_q];   // stop bit (1) releases the line
                  if (idx_q != IDX_W'(FRAME_BITS - 1)) idx_q <= idx_q + 1'b1;
               end
            end
            ACK: begin
               if (timeout) begin
                  dat_q <= 1'b0;
                  err_q <= 1'b1;
               end else if (clk_fall) begin
                  err_q <= dat_lvl;       // device holds data low to ack
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      tx_ready   = 1'b0;
      tx_done    = 1'b0;
      tx_err     = 1'b0;
      ps2_clk_oe = 1'b0;
      unique case (state)
         IDLE:         tx_ready = 1'b1;
         INHIBIT, RTS: ps2_clk_oe = 1'b1;
         WAIT_IDLE: begin
            if (lines_idle) begin
               tx_ready = 1'b1;
               tx_done  = ~err_q;
               tx_err   = err_q;
            end
         end
         default: ;
      endcase
   end

   assign ps2_dat_oe = dat_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

   localparam int INH      = 5000;   // CLK_HZ/10_000 at 50 MHz
   localparam int START_TO = 3000;
   localparam int PKT_TO   = 2000;
   localparam int FILT     = 8;
   localparam int HALF     = 40;     // device clock half period in sys cycles

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [7:0] tx_data   = 8'h00;
   logic       tx_valid  = 1'b0;
   logic       tx_ready, tx_done, tx_err;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       ps2_clk_in, ps2_dat_in;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   // Open-drain bus with pull-ups: either side may pull low.
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .CLK_HZ          (50_000_000),
      .START_TO_CYCLES (START_TO),
      .PKT_TO_CYCLES   (PKT_TO),
      .FILTER_LEN      (FILT)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #5 sys_clk = ~sys_clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [9:0] exp_frame_q[$];
   logic [9:0] cap_frame_q[$];
   logic       exp_err_q[$];
   logic [9:0] exp_f, cap_f;
   logic       exp_e;

   function automatic void check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endfunction

   // Completion monitor: every pulse must match the oldest queued outcome.
   always @(negedge sys_clk) begin
      if (sys_rst_n && (tx_done || tx_err)) begin
         if (exp_err_q.size() == 0) begin
            check("unexpected_pulse", {tx_done, tx_err}, 0);
         end else begin
            exp_e = exp_err_q.pop_front();
            check("outcome_done_err", {tx_done, tx_err}, exp_e ? 2'b01 : 2'b10);
         end
      end
   end

   // Frame monitor: every frame the device model captured must match.
   always @(negedge sys_clk) begin
      if (cap_frame_q.size() > 0) begin
         cap_f = cap_frame_q.pop_front();
         if (exp_frame_q.size() == 0) begin
            check("unexpected_frame", cap_f, 0);
         end else begin
            exp_f = exp_frame_q.pop_front();
            check("frame_bits", cap_f, exp_f);
         end
      end
   end

   // Device model: clocks nfall periods, samples data while the clock is high,
   // and on a full frame acks (or not) on the 11th clock.
   task automatic dev_frame(input logic ack, input int nfall);
      logic [9:0] cap;
      int t;
      cap = '0;
      t = 0;
      while (!(ps2_dat_in == 1'b0 && ps2_clk_in == 1'b1) && t < 20000) begin
         @(posedge sys_clk); #1; t++;
      end
      if (t >= 20000) begin
         check("start_bit_wait", 0, 1);
         return;
      end
      repeat (20) @(posedge sys_clk);
      for (int i = 0; i < nfall; i++) begin
         #1 dev_clk_low = 1'b1;
         repeat (HALF) @(posedge sys_clk);
         #1 dev_clk_low = 1'b0;
         repeat (HALF / 2) @(posedge sys_clk);
         cap[i] = ps2_dat_in;
         if (i == 9) dev_dat_low = ack;
         repeat (HALF / 2) @(posedge sys_clk);
      end
      if (nfall == 10) begin
         #1 dev_clk_low = 1'b1;
         repeat (HALF) @(posedge sys_clk);
         #1 dev_clk_low = 1'b0;
         repeat (HALF) @(posedge sys_clk);
         #1 dev_dat_low = 1'b0;
         cap_frame_q.push_back(cap);
      end
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (!tx_ready && t < 5000) begin
         @(posedge sys_clk); #1; t++;
      end
      if (t >= 5000) check("ready_return", 0, 1);
   endtask

   // Issues one byte and measures the inhibit / request-to-send phase.
   task automatic start_tx(input logic [7:0] d);
      int n, dat_at, t;
      wait_ready();
      @(posedge sys_clk); #1;
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge sys_clk); #1;
      tx_valid = 1'b0;
      check("ready_fall", tx_ready, 0);
      check("clk_oe_rise", ps2_clk_oe, 1);
      n = 1;
      dat_at = ps2_dat_oe ? 1 : 0;
      t = 0;
      while (ps2_clk_oe && t < 20000) begin
         @(posedge sys_clk); #1; t++;
         if (ps2_clk_oe) begin
            n++;
            if (ps2_dat_oe && dat_at == 0) dat_at = n;
         end
      end
      check("inhibit_len", n, INH + 1);
      check("rts_lead", dat_at, n);
      check("start_bit_held", ps2_dat_oe, 1);
   endtask

   task automatic poke_busy();
      repeat (300) @(posedge sys_clk);
      #1 tx_data = 8'h12;
      tx_valid = 1'b1;
      repeat (50) @(posedge sys_clk);
      #1 check("ready_in_shift", tx_ready, 0);
      repeat (50) @(posedge sys_clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic [9:0] f, input logic ack, input logic poke);
      exp_frame_q.push_back(f);
      exp_err_q.push_back(!ack);
      start_tx(d);
      fork
         dev_frame(ack, 10);
         if (poke) poke_busy();
      join
      wait_ready();
      repeat (10) @(posedge sys_clk);
   endtask

   initial begin
      #900_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_dat_oe", ps2_dat_oe, 0);
      check("rst_done", tx_done, 0);
      check("rst_err", tx_err, 0);
      sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;
      check("ready_after_reset", tx_ready, 1);

      // Device-initiated clocking while idle is ignored.
      for (int i = 0; i < 11; i++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) @(posedge sys_clk);
         #1 dev_clk_low = 1'b0;
         repeat (HALF) @(posedge sys_clk);
         #1;
      end
      repeat (20) @(posedge sys_clk); #1;
      check("idle_ignore_ready", tx_ready, 1);
      check("idle_ignore_clk_oe", ps2_clk_oe, 0);
      check("idle_ignore_dat_oe", ps2_dat_oe, 0);

      // frame = {stop, odd parity, d7..d0}
      send(8'hED, 10'b11_1110_1101, 1'b1, 1'b0);
      send(8'hF4, 10'b10_1111_0100, 1'b1, 1'b1);
      send(8'h00, 10'b11_0000_0000, 1'b1, 1'b0);
      send(8'hFF, 10'b11_1111_1111, 1'b0, 1'b0);   // device withholds ack

      // Reset while bit 4 is being driven.
      start_tx(8'h55);
      dev_frame(1'b1, 4);
      #1 dev_clk_low = 1'b1;
      repeat (20) @(posedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      check("rst_mid_clk_oe", ps2_clk_oe, 0);
      check("rst_mid_dat_oe", ps2_dat_oe, 0);
      repeat (5) @(posedge sys_clk);
      #1 dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      sys_rst_n = 1'b1;
      repeat (50) @(posedge sys_clk); #1;
      check("rst_mid_ready", tx_ready, 1);
      check("rst_mid_clk_oe_after", ps2_clk_oe, 0);

`ifdef PS2_TX_TIMEOUT_EN
      begin
         int k;
         exp_err_q.push_back(1'b1);
         start_tx(8'hAB);
         k = 0;
         while (!tx_err && k < START_TO + 200) begin
            @(posedge sys_clk); #1; k++;
         end
         check("start_timeout_window", (k >= START_TO && k <= START_TO + 2 * FILT + 6) ? 1 : 0, 1);
         check("timeout_clk_oe", ps2_clk_oe, 0);
         check("timeout_dat_oe", ps2_dat_oe, 0);
         wait_ready();
         repeat (10) @(posedge sys_clk);
      end
`endif

      repeat (10) @(posedge sys_clk);
      check("outcomes_drained", exp_err_q.size(), 0);
      check("frames_drained", exp_frame_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
